// File: rtl/extbus_6502_pkg.sv
`default_nettype none
// ============================================================================
// Module      : extbus_6502_pkg
// Description : Shared constants for the 6502-style external bus: target
//               register map and the values the bus rests at when idle.
// Revision    : 1.0 - initial release
// ============================================================================
package extbus_6502_pkg;

    // Target register map
    localparam logic [2:0] ADDR_HI  = 3'd0;
    localparam logic [2:0] ADDR_MID = 3'd1;
    localparam logic [2:0] ADDR_LO  = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;

    // Bus idle values (also the reset values)
    localparam logic       BUS_IDLE_PHY2 = 1'b0;
    localparam logic       BUS_IDLE_CS_N = 1'b1;
    localparam logic       BUS_IDLE_RW_N = 1'b1;
    localparam logic [2:0] BUS_IDLE_A    = 3'd0;

endpackage : extbus_6502_pkg
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer with a configurable reset value.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset
//               i_d   - asynchronous input
//               o_q   - synchronized output (2 cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/extbus_master_6502.sv
`default_nettype none
// ============================================================================
// Module      : extbus_master_6502
// Description : CPU-side initiator for the 6502-style external bus. Divides
//               intbus_clk into a free-running PHY2, runs one bus cycle per
//               accepted request, stretches PHY2-high on reads while RDY is
//               low (bounded by MAX_WAIT) and synchronizes IRQ#.
// Ports       : intbus_clk/intbus_reset_n - clock, async active-low reset
//               req_*  - request port (valid/ready handshake)
//               rsp_*  - one-cycle completion pulse with read data/timeout
//               irq    - synchronized active-high interrupt
//               extbus_* - external bus pins (D is tri-stated when not writing)
// Revision    : 1.0 - initial release
// ============================================================================
module extbus_master_6502
    import extbus_6502_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int MAX_WAIT    = 15
) (
    input  logic       intbus_clk,
    input  logic       intbus_reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wrdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rddata,
    output logic       rsp_timeout,
    output logic       irq,
    output logic       extbus_phy2,
    output logic       extbus_cs_n,
    output logic       extbus_rw_n,
    output logic [2:0] extbus_a,
    inout  wire  [7:0] extbus_d,
    input  logic       extbus_rdy,
    input  logic       extbus_irq_n
);

    localparam int c_PHASE_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int c_WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [c_PHASE_W-1:0] c_PHASE_LAST = c_PHASE_W'(HALF_PERIOD - 1);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_MAX   = c_WAIT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PEND = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4   // one cycle after the closing PHY2 fall: release + respond
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [c_PHASE_W-1:0]  r_phase_cnt;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic                  r_phy2;
    logic                  r_gap;
    logic                  r_req_write;
    logic [2:0]            r_req_addr;
    logic [7:0]            r_req_wrdata;
    logic                  r_cs_n;
    logic                  r_rw_n;
    logic [2:0]            r_a;
    logic [7:0]            r_d_out;
    logic                  r_d_oe;
    logic [7:0]            r_rd_capture;
    logic                  r_timeout_flag;
    logic                  r_rsp_valid;
    logic [7:0]            r_rsp_rddata;
    logic                  r_rsp_timeout;

    logic w_rdy_s;
    logic w_irq_n_s;
    logic w_at_last;
    logic w_data_last_read;
    logic w_stretch;
    logic w_timeout;
    logic w_toggle;
    logic w_fall;
    logic w_rise;
    logic w_start;
    logic w_accept;
    logic w_enter_addr;
    logic       w_src_write;
    logic [2:0] w_src_addr;
    logic [7:0] w_src_wrdata;

    sync2 #(.RESET_VALUE(1'b1)) u_rdy_sync (
        .clk   (intbus_clk),
        .rst_n (intbus_reset_n),
        .i_d   (extbus_rdy),
        .o_q   (w_rdy_s)
    );

    sync2 #(.RESET_VALUE(1'b1)) u_irq_sync (
        .clk   (intbus_clk),
        .rst_n (intbus_reset_n),
        .i_d   (extbus_irq_n),
        .o_q   (w_irq_n_s)
    );

    // PHY2 generator control. The stretch decision is taken only at the last
    // count of a read's high phase; the counter holds while stretching.
    assign w_at_last        = (r_phase_cnt == c_PHASE_LAST);
    assign w_data_last_read = (r_state == S_DATA) && !r_req_write && w_at_last;
    assign w_stretch        = w_data_last_read && !w_rdy_s && (r_wait_cnt < c_WAIT_MAX);
    assign w_timeout        = w_data_last_read && !w_rdy_s && (r_wait_cnt == c_WAIT_MAX);
    assign w_toggle         = w_at_last && !w_stretch;
    assign w_fall           = w_toggle && r_phy2;
    assign w_rise           = w_toggle && !r_phy2;

    // r_gap is set when a cycle completes and cleared by the next PHY2 fall,
    // so that fall cannot start a new cycle: a full PHY2 period with CS# high
    // always separates two bus cycles.
    assign w_start = w_fall && !r_gap;

    // A request accepted on the very edge PHY2 falls goes straight to ADDR,
    // so the bus is loaded from the live request rather than the latch.
    assign w_src_write  = (r_state == S_IDLE) ? req_write  : r_req_write;
    assign w_src_addr   = (r_state == S_IDLE) ? req_addr   : r_req_addr;
    assign w_src_wrdata = (r_state == S_IDLE) ? req_wrdata : r_req_wrdata;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = w_start ? S_ADDR : S_PEND;
                end
            end
            S_PEND:  if (w_start) w_next_state = S_ADDR;
            S_ADDR:  if (w_rise)  w_next_state = S_DATA;
            S_DATA:  if (w_fall)  w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_enter_addr = (w_next_state == S_ADDR) && (r_state != S_ADDR);

    always_ff @(posedge intbus_clk or negedge intbus_reset_n) begin
        if (!intbus_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge intbus_clk or negedge intbus_reset_n) begin
        if (!intbus_reset_n) begin
            r_phase_cnt    <= '0;
            r_phy2         <= BUS_IDLE_PHY2;
            r_wait_cnt     <= '0;
            r_gap          <= 1'b0;
            r_req_write    <= 1'b0;
            r_req_addr     <= 3'd0;
            r_req_wrdata   <= 8'h00;
            r_cs_n         <= BUS_IDLE_CS_N;
            r_rw_n         <= BUS_IDLE_RW_N;
            r_a            <= BUS_IDLE_A;
            r_d_out        <= 8'h00;
            r_d_oe         <= 1'b0;
            r_rd_capture   <= 8'h00;
            r_timeout_flag <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_rddata   <= 8'h00;
            r_rsp_timeout  <= 1'b0;
        end else begin
            if (w_toggle) begin
                r_phase_cnt <= '0;
                r_phy2      <= ~r_phy2;
            end else if (!w_stretch) begin
                r_phase_cnt <= r_phase_cnt + 1'b1;
            end

            if ((r_state == S_ADDR) && w_rise) begin
                r_wait_cnt <= '0;
            end else if (w_stretch) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (r_state == S_DONE) begin
                r_gap <= 1'b1;
            end else if (w_fall) begin
                r_gap <= 1'b0;
            end

            if (w_accept) begin
                r_req_write  <= req_write;
                r_req_addr   <= req_addr;
                r_req_wrdata <= req_wrdata;
            end

            if (w_enter_addr) begin
                r_cs_n  <= 1'b0;
                r_rw_n  <= ~w_src_write;
                r_a     <= w_src_addr;
                r_d_out <= w_src_wrdata;
                r_d_oe  <= w_src_write;
            end else if (r_state == S_DONE) begin
                r_cs_n <= BUS_IDLE_CS_N;
                r_rw_n <= BUS_IDLE_RW_N;
                r_a    <= BUS_IDLE_A;
                r_d_oe <= 1'b0;
            end

            if ((r_state == S_DATA) && w_fall) begin
                r_rd_capture   <= extbus_d;
                r_timeout_flag <= w_timeout;
            end

            r_rsp_valid   <= (r_state == S_DONE);
            r_rsp_timeout <= (r_state == S_DONE) && r_timeout_flag;
            if ((r_state == S_DONE) && !r_req_write) begin
                r_rsp_rddata <= r_rd_capture;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rddata  = r_rsp_rddata;
    assign rsp_timeout = r_rsp_timeout;
    assign irq         = ~w_irq_n_s;
    assign extbus_phy2 = r_phy2;
    assign extbus_cs_n = r_cs_n;
    assign extbus_rw_n = r_rw_n;
    assign extbus_a    = r_a;
    assign extbus_d    = r_d_oe ? r_d_out : 8'bz;

endmodule : extbus_master_6502
`default_nettype wire

// File: tb/tb_extbus_master_6502.sv
`default_nettype none
// ============================================================================
// Module      : tb_extbus_master_6502
// Description : Self-checking bench for extbus_master_6502 with a simple bus
//               target model (drives D on reads, captures D on writes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_extbus_master_6502;
    import extbus_6502_pkg::*;

    logic       intbus_clk = 1'b0;
    logic       intbus_reset_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [2:0] req_addr;
    logic [7:0] req_wrdata;
    logic       rsp_valid;
    logic [7:0] rsp_rddata;
    logic       rsp_timeout;
    logic       irq;
    logic       extbus_phy2;
    logic       extbus_cs_n;
    logic       extbus_rw_n;
    logic [2:0] extbus_a;
    wire  [7:0] extbus_d;
    logic       extbus_rdy;
    logic       extbus_irq_n;

    logic [7:0] tgt_rd_data;
    logic [7:0] tgt_wr_data;
    logic [2:0] tgt_wr_addr;
    wire        tgt_drive = !extbus_cs_n && extbus_rw_n && extbus_phy2;

    assign extbus_d = tgt_drive ? tgt_rd_data : 8'bz;

    always @(negedge extbus_phy2) begin
        if (!extbus_cs_n && !extbus_rw_n) begin
            tgt_wr_data <= extbus_d;
            tgt_wr_addr <= extbus_a;
        end
    end

    extbus_master_6502 #(.HALF_PERIOD(4), .MAX_WAIT(15)) dut (
        .intbus_clk     (intbus_clk),
        .intbus_reset_n (intbus_reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wrdata     (req_wrdata),
        .rsp_valid      (rsp_valid),
        .rsp_rddata     (rsp_rddata),
        .rsp_timeout    (rsp_timeout),
        .irq            (irq),
        .extbus_phy2    (extbus_phy2),
        .extbus_cs_n    (extbus_cs_n),
        .extbus_rw_n    (extbus_rw_n),
        .extbus_a       (extbus_a),
        .extbus_d       (extbus_d),
        .extbus_rdy     (extbus_rdy),
        .extbus_irq_n   (extbus_irq_n)
    );

    always #5 intbus_clk = ~intbus_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where rsp_valid is seen
    // (or after the cycle budget, with ok=0).
    task automatic run_txn(input logic wr, input logic [2:0] addr, input logic [7:0] wd,
                           output int lat, output int cs_pre, output int cs_low,
                           output int hi_len, output logic [7:0] rd,
                           output logic to, output logic ok);
        int n;
        lat = 0; cs_pre = 0; cs_low = 0; hi_len = 0; rd = 8'h00; to = 1'b0; ok = 1'b0;
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wrdata = wd;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge intbus_clk);
            n++;
        end
        @(negedge intbus_clk);
        req_valid = 1'b0;
        n = 0;
        while (n < 200) begin
            if (rsp_valid) begin
                ok = 1'b1;
                rd = rsp_rddata;
                to = rsp_timeout;
                break;
            end
            if (extbus_cs_n) begin
                if (cs_low == 0) cs_pre++;
            end else begin
                cs_low++;
                if (extbus_phy2) hi_len++;
            end
            @(negedge intbus_clk);
            n++;
            lat++;
        end
    endtask

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        int         exp_cs;
        int         exp_hi;
    } vec_t;

    vec_t vecs [5];

    int         lat, pre, csl, hi, n, cnt;
    logic [7:0] rd;
    logic       to, ok, ok2;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // write rsp_rddata holds the previous read value
        vecs[0] = '{wr: 1'b1, addr: ADDR_LO,  data: 8'h5A, exp_rd: 8'h00, exp_cs: 9, exp_hi: 4};
        vecs[1] = '{wr: 1'b0, addr: ADDR_HI,  data: 8'h3C, exp_rd: 8'h3C, exp_cs: 9, exp_hi: 4};
        vecs[2] = '{wr: 1'b1, addr: ADDR_MID, data: 8'hFF, exp_rd: 8'h3C, exp_cs: 9, exp_hi: 4};
        vecs[3] = '{wr: 1'b0, addr: ADDR_LO,  data: 8'h00, exp_rd: 8'h00, exp_cs: 9, exp_hi: 4};
        vecs[4] = '{wr: 1'b0, addr: DATA,     data: 8'hC3, exp_rd: 8'hC3, exp_cs: 9, exp_hi: 4};

        req_valid = 1'b0; req_write = 1'b0; req_addr = 3'd0; req_wrdata = 8'h00;
        extbus_rdy = 1'b1; extbus_irq_n = 1'b1; tgt_rd_data = 8'h00;
        tgt_wr_data = 8'h00; tgt_wr_addr = 3'd0;
        intbus_reset_n = 1'b1;
        #2 intbus_reset_n = 1'b0;
        #1;
        check("reset_phy2",     32'(extbus_phy2), 32'd0);
        check("reset_cs_n",     32'(extbus_cs_n), 32'd1);
        check("reset_rw_n",     32'(extbus_rw_n), 32'd1);
        check("reset_a",        32'(extbus_a),    32'd0);
        check("reset_req_rdy",  32'(req_ready),   32'd1);
        check("reset_rsp_vld",  32'(rsp_valid),   32'd0);
        check("reset_rddata",   32'(rsp_rddata),  32'd0);
        check("reset_timeout",  32'(rsp_timeout), 32'd0);
        check("reset_irq",      32'(irq),         32'd0);

        repeat (2) @(negedge intbus_clk);
        intbus_reset_n = 1'b1;

        // Free-running PHY2: 4 cycles high, 4 cycles low
        n = 0;
        while (!extbus_phy2 && n < 50) begin @(negedge intbus_clk); n++; end
        cnt = 0;
        while (extbus_phy2 && cnt < 50) begin cnt++; @(negedge intbus_clk); end
        check("phy2_high_len", 32'(cnt), 32'd4);
        cnt = 0;
        while (!extbus_phy2 && cnt < 50) begin cnt++; @(negedge intbus_clk); end
        check("phy2_low_len", 32'(cnt), 32'd4);

        // Table-driven single transactions
        for (int i = 0; i < 5; i++) begin
            repeat (20) @(negedge intbus_clk);
            tgt_rd_data = vecs[i].data;
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, lat, pre, csl, hi, rd, to, ok);
            check($sformatf("v%0d_rsp_seen", i),  32'(ok), 32'd1);
            check($sformatf("v%0d_latency", i),   32'((lat >= 9) && (lat <= 16)), 32'd1);
            check($sformatf("v%0d_cs_low", i),    32'(csl), 32'(vecs[i].exp_cs));
            check($sformatf("v%0d_hi_len", i),    32'(hi),  32'(vecs[i].exp_hi));
            check($sformatf("v%0d_timeout", i),   32'(to),  32'd0);
            check($sformatf("v%0d_rddata", i),    32'(rd),  32'(vecs[i].exp_rd));
            check($sformatf("v%0d_ready", i),     32'(req_ready), 32'd1);
            if (vecs[i].wr) begin
                check($sformatf("v%0d_tgt_wdata", i), 32'(tgt_wr_data), 32'(vecs[i].data));
                check($sformatf("v%0d_tgt_waddr", i), 32'(tgt_wr_addr), 32'(vecs[i].addr));
            end
            @(negedge intbus_clk);
            check($sformatf("v%0d_pulse_width", i), 32'(rsp_valid), 32'd0);
        end

        // Read with RDY low for 6 cycles after the PHY2 rise: stretch of 5
        repeat (20) @(negedge intbus_clk);
        tgt_rd_data = 8'hA7;
        fork
            run_txn(1'b0, ADDR_MID, 8'h00, lat, pre, csl, hi, rd, to, ok);
            begin : rdy_drv
                int k;
                k = 0;
                while (!(extbus_phy2 && !extbus_cs_n) && k < 200) begin
                    @(negedge intbus_clk);
                    k++;
                end
                extbus_rdy = 1'b0;
                repeat (6) @(negedge intbus_clk);
                extbus_rdy = 1'b1;
            end
        join
        check("stretch_rsp_seen", 32'(ok),  32'd1);
        check("stretch_hi_len",   32'(hi),  32'd9);
        check("stretch_cs_low",   32'(csl), 32'd14);
        check("stretch_rddata",   32'(rd),  32'hA7);
        check("stretch_timeout",  32'(to),  32'd0);

        // Read with RDY stuck low: 4+15 high cycles then timeout
        repeat (20) @(negedge intbus_clk);
        tgt_rd_data = 8'h99;
        extbus_rdy  = 1'b0;
        run_txn(1'b0, ADDR_HI, 8'h00, lat, pre, csl, hi, rd, to, ok);
        check("tmo_rsp_seen", 32'(ok),  32'd1);
        check("tmo_hi_len",   32'(hi),  32'd19);
        check("tmo_cs_low",   32'(csl), 32'd24);
        check("tmo_timeout",  32'(to),  32'd1);
        check("tmo_rddata",   32'(rd),  32'h99);
        check("tmo_cs_rel",   32'(extbus_cs_n), 32'd1);
        extbus_rdy = 1'b1;
        @(negedge intbus_clk);
        check("tmo_flag_pulse", 32'(rsp_timeout), 32'd0);

        // Back-to-back: write then read offered as soon as ready returns
        repeat (20) @(negedge intbus_clk);
        tgt_rd_data = 8'h42;
        run_txn(1'b1, ADDR_HI, 8'h10, lat, pre, csl, hi, rd, to, ok);
        run_txn(1'b0, DATA,    8'h00, lat, pre, csl, hi, rd, to, ok2);
        check("b2b_pulses",    32'(int'(ok) + int'(ok2)), 32'd2);
        check("b2b_tgt_wdata", 32'(tgt_wr_data), 32'h10);
        check("b2b_cs_gap",    32'(pre), 32'd14);
        check("b2b_latency2",  32'(lat), 32'd23);
        check("b2b_rddata",    32'(rd),  32'h42);
        check("b2b_cs_low2",   32'(csl), 32'd9);

        // Reset in the middle of a write's DATA phase
        repeat (20) @(negedge intbus_clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = ADDR_LO; req_wrdata = 8'h77;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge intbus_clk); n++; end
        @(negedge intbus_clk);
        req_valid = 1'b0;
        n = 0;
        while (!(extbus_phy2 && !extbus_cs_n) && n < 200) begin @(negedge intbus_clk); n++; end
        check("rst_mid_reached", 32'(extbus_phy2 && !extbus_cs_n), 32'd1);
        @(negedge intbus_clk);
        intbus_reset_n = 1'b0;
        #1;
        check("rst_mid_phy2",    32'(extbus_phy2), 32'd0);
        check("rst_mid_cs_n",    32'(extbus_cs_n), 32'd1);
        check("rst_mid_rw_n",    32'(extbus_rw_n), 32'd1);
        check("rst_mid_a",       32'(extbus_a),    32'd0);
        check("rst_mid_ready",   32'(req_ready),   32'd1);
        check("rst_mid_rddata",  32'(rsp_rddata),  32'd0);
        repeat (2) @(negedge intbus_clk);
        intbus_reset_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge intbus_clk);
            if (rsp_valid) cnt++;
        end
        check("rst_mid_no_rsp", 32'(cnt), 32'd0);
        tgt_rd_data = 8'h00;
        run_txn(1'b0, ADDR_MID, 8'h00, lat, pre, csl, hi, rd, to, ok);
        check("post_rst_rsp_seen", 32'(ok),  32'd1);
        check("post_rst_cs_low",   32'(csl), 32'd9);
        check("post_rst_rddata",   32'(rd),  32'h00);
        tgt_rd_data = 8'h6E;
        repeat (20) @(negedge intbus_clk);
        run_txn(1'b0, ADDR_MID, 8'h00, lat, pre, csl, hi, rd, to, ok);
        check("post_rst_rddata2",  32'(rd),  32'h6E);

        // IRQ synchronizer: 2 cycles each way
        repeat (4) @(negedge intbus_clk);
        extbus_irq_n = 1'b0;
        @(negedge intbus_clk);
        check("irq_assert_1cyc",  32'(irq), 32'd0);
        @(negedge intbus_clk);
        check("irq_assert_2cyc",  32'(irq), 32'd1);
        extbus_irq_n = 1'b1;
        @(negedge intbus_clk);
        check("irq_release_1cyc", 32'(irq), 32'd1);
        @(negedge intbus_clk);
        check("irq_release_2cyc", 32'(irq), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_extbus_master_6502
`default_nettype wire
